// File: rtl/stage_action_merge_pkg.sv
// ---------------------------------------------------------------------------
// stage_merge_pkg
// Shared definitions for the stage action merge block:
//   MERGE_PRIO / MERGE_OR  - merge mode selectors for MERGE_MODE
//   MAX_SUB_UNIT           - largest supported number of action lanes
//   NOP_ACT_BIT            - NOP action constant; a NOP word is this bit
//                            replicated across the full action width
//   act_w()                - action word width from container geometry
//   popcount()             - number of set lane valids (up to MAX_SUB_UNIT)
// ---------------------------------------------------------------------------
package stage_merge_pkg;

    localparam int MERGE_PRIO   = 0;
    localparam int MERGE_OR     = 1;
    localparam int MAX_SUB_UNIT = 16;
    localparam int POP_W        = 5;

    // The NOP action is all zeros at any width.
    localparam bit NOP_ACT_BIT  = 1'b0;

    function automatic int act_w(input int act_len, input int num_phv_cont);
        return act_len * num_phv_cont;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_SUB_UNIT-1:0] vec);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_SUB_UNIT; i++) begin
            n = n + POP_W'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/stage_action_merge_if.sv
// ---------------------------------------------------------------------------
// stage_action_merge_if
// Bundles the lane/PHV/VLAN inputs, the merged outputs and both ready
// signals of the merge stage.
//   master modport : upstream sub-units + downstream action engine side
//   slave modport  : the merge stage itself
// Input side : sub_action_in, sub_action_valid_in, phv_in, phv_valid_in,
//              vlan_in, vlan_valid_in, ready_in (downstream ready)
// Output side: ready_out, action_out, phv_out, hit_vec_out, valid_out,
//              vlan_out, vlan_valid_out
// ---------------------------------------------------------------------------
interface stage_action_merge_if
    import stage_merge_pkg::*;
#(
    parameter int NUM_SUB_UNIT   = 8,
    parameter int ACT_W          = act_w(64, 65),
    parameter int PHV_LEN        = 2304,
    parameter int C_VLANID_WIDTH = 12
);

    logic [NUM_SUB_UNIT*ACT_W-1:0] sub_action_in;
    logic [NUM_SUB_UNIT-1:0]       sub_action_valid_in;
    logic [PHV_LEN-1:0]            phv_in;
    logic                          phv_valid_in;
    logic [C_VLANID_WIDTH-1:0]     vlan_in;
    logic                          vlan_valid_in;
    logic                          ready_out;

    logic [ACT_W-1:0]              action_out;
    logic [PHV_LEN-1:0]            phv_out;
    logic [NUM_SUB_UNIT-1:0]       hit_vec_out;
    logic                          valid_out;
    logic [C_VLANID_WIDTH-1:0]     vlan_out;
    logic                          vlan_valid_out;
    logic                          ready_in;

    modport master (
        output sub_action_in, sub_action_valid_in, phv_in, phv_valid_in,
               vlan_in, vlan_valid_in, ready_in,
        input  ready_out, action_out, phv_out, hit_vec_out, valid_out,
               vlan_out, vlan_valid_out
    );

    modport slave (
        input  sub_action_in, sub_action_valid_in, phv_in, phv_valid_in,
               vlan_in, vlan_valid_in, ready_in,
        output ready_out, action_out, phv_out, hit_vec_out, valid_out,
               vlan_out, vlan_valid_out
    );

endinterface

// File: rtl/stage_action_merge_skid.sv
// ---------------------------------------------------------------------------
// merge_skid_buf
// Generic 2-entry ready/valid register slice: a head (output) register plus
// one skid register that catches the beat accepted while the head stalls.
//   clk, rst_n                 : clock, synchronous active-low reset
//   up_data/up_valid/up_ready  : upstream side; up_ready = skid empty
//   dn_data/dn_valid/dn_ready  : downstream side, driven from the head reg
// ---------------------------------------------------------------------------
module merge_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic              dn_valid,
    input  logic              dn_ready
);

    logic [DATA_W-1:0] head_data;
    logic              head_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic              take;

    // Ready comes straight from the skid flop, so it is registered and only
    // drops the cycle after the skid has captured a beat.
    assign up_ready = !skid_valid;
    assign take     = up_valid && up_ready;
    assign dn_data  = head_data;
    assign dn_valid = head_valid;

    // A full skid implies a full head; while it is full nothing is accepted,
    // so the only event is a downstream transfer that promotes the skid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (dn_ready) begin
                head_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (take) begin
            if (!head_valid || dn_ready) begin
                head_data  <= up_data;
                head_valid <= 1'b1;
            end else begin
                skid_data  <= up_data;
                skid_valid <= 1'b1;
            end
        end else if (dn_ready) begin
            head_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stage_action_merge.sv
// ---------------------------------------------------------------------------
// stage_action_merge
// Collapses NUM_SUB_UNIT action lanes into one action word (priority select
// or bitwise OR of the valid lanes), carries PHV and VLAN sideband with it
// and registers the result behind a 2-entry skid buffer.
//   axis_clk, aresetn  : clock, synchronous active-low reset
//   bus (slave)        : lanes/PHV/VLAN in, merged action/PHV/VLAN/hit vector
//                        out, ready_out upstream, ready_in downstream
//   clr_cnt            : synchronous statistics clear
//   hit_cnt, miss_cnt, multi_hit_cnt : saturating per-accept statistics
// Build option: define STAGE_MERGE_STATS_EN to keep the statistics counters;
// otherwise they read 0 and clr_cnt is ignored. The datapath is unchanged.
// ---------------------------------------------------------------------------
module stage_action_merge
    import stage_merge_pkg::*;
#(
    parameter int NUM_SUB_UNIT   = 8,
    parameter int ACT_LEN        = 64,
    parameter int NUM_PHV_CONT   = 65,
    parameter int PHV_LEN        = 2304,
    parameter int C_VLANID_WIDTH = 12,
    parameter int MERGE_MODE     = MERGE_PRIO,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 axis_clk,
    input  logic                 aresetn,
    stage_action_merge_if.slave  bus,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] multi_hit_cnt
);

    localparam int ACT_W  = act_w(ACT_LEN, NUM_PHV_CONT);
    localparam int DATA_W = NUM_SUB_UNIT + 1 + C_VLANID_WIDTH + PHV_LEN + ACT_W;

    logic [ACT_W-1:0]  merged;
    logic              lane_found;
    logic              accept;
    logic [DATA_W-1:0] entry;
    logic [DATA_W-1:0] head_data;
    logic              head_valid;
    logic              head_vlan_valid;

    assign accept = bus.phv_valid_in && bus.ready_out;

    // Lane merge. With no valid lane both modes fall through to the NOP word.
    // Priority mode takes the first valid lane counting up from index 0;
    // OR mode masks invalid lanes before folding them together.
    always_comb begin
        merged     = {ACT_W{NOP_ACT_BIT}};
        lane_found = 1'b0;
        for (int i = 0; i < NUM_SUB_UNIT; i++) begin
            if (bus.sub_action_valid_in[i]) begin
                if (MERGE_MODE == MERGE_OR) begin
                    merged = merged | bus.sub_action_in[i*ACT_W +: ACT_W];
                end else if (!lane_found) begin
                    merged     = bus.sub_action_in[i*ACT_W +: ACT_W];
                    lane_found = 1'b1;
                end
            end
        end
    end

    assign entry = {bus.sub_action_valid_in, bus.vlan_valid_in, bus.vlan_in,
                    bus.phv_in, merged};

    merge_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (axis_clk),
        .rst_n    (aresetn),
        .up_data  (entry),
        .up_valid (bus.phv_valid_in),
        .up_ready (bus.ready_out),
        .dn_data  (head_data),
        .dn_valid (head_valid),
        .dn_ready (bus.ready_in)
    );

    assign {bus.hit_vec_out, head_vlan_valid, bus.vlan_out, bus.phv_out,
            bus.action_out} = head_data;
    assign bus.valid_out      = head_valid;
    // The head keeps its old payload after draining, so the VLAN flag must
    // be gated to avoid reporting a stale VLAN with no beat present.
    assign bus.vlan_valid_out = head_vlan_valid && head_valid;

`ifdef STAGE_MERGE_STATS_EN
    logic [POP_W-1:0] hit_num;

    assign hit_num = popcount(MAX_SUB_UNIT'(bus.sub_action_valid_in));

    // Counters advance once per accepted transaction and stick at all-ones.
    // A clear wins over an increment landing in the same cycle.
    always_ff @(posedge axis_clk) begin
        if (!aresetn || clr_cnt) begin
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            multi_hit_cnt <= '0;
        end else if (accept) begin
            if (hit_num == '0) begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
            end else begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
                if (hit_num >= POP_W'(2) && multi_hit_cnt != '1) begin
                    multi_hit_cnt <= multi_hit_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end
`else
    logic unused_stats;

    assign unused_stats  = clr_cnt ^ accept;
    assign hit_cnt       = '0;
    assign miss_cnt      = '0;
    assign multi_hit_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_action_merge.sv
// ---------------------------------------------------------------------------
// tb_stage_action_merge
// Drives one priority-mode and one OR-mode instance of stage_action_merge
// (small geometry, 4-bit counters) with identical stimulus. Every accepted
// transaction pushes its expected result to a queue; every output beat is
// compared against the queue head and popped when it transfers.
// ---------------------------------------------------------------------------
module tb_stage_action_merge;
    import stage_merge_pkg::*;

    localparam int NSU = 8;
    localparam int AW  = 16;
    localparam int PW  = 16;
    localparam int VW  = 12;
    localparam int CW  = 4;

`ifdef STAGE_MERGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0]  act_p;
        logic [AW-1:0]  act_o;
        logic [PW-1:0]  phv;
        logic [NSU-1:0] hit;
        logic [VW-1:0]  vlan;
        logic           vv;
    } exp_t;

    logic clk;
    logic rstn;
    logic clr_cnt;
    logic [NSU*AW-1:0] sub_action;
    logic [NSU-1:0]    sub_valid;
    logic [PW-1:0]     phv;
    logic              phv_valid;
    logic [VW-1:0]     vlan;
    logic              vlan_valid;
    logic              ready_in;
    logic [CW-1:0]     hit_p, miss_p, multi_p, hit_o, miss_o, multi_o;
    logic [NSU*AW-1:0] lanes;

    exp_t sb[$];
    int   n_compared;
    int   n_mismatched;

    stage_action_merge_if #(.NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PW),
                            .C_VLANID_WIDTH(VW)) if_p ();
    stage_action_merge_if #(.NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PW),
                            .C_VLANID_WIDTH(VW)) if_o ();

    assign if_p.sub_action_in = sub_action;   assign if_o.sub_action_in = sub_action;
    assign if_p.sub_action_valid_in = sub_valid;
    assign if_o.sub_action_valid_in = sub_valid;
    assign if_p.phv_in = phv;                 assign if_o.phv_in = phv;
    assign if_p.phv_valid_in = phv_valid;     assign if_o.phv_valid_in = phv_valid;
    assign if_p.vlan_in = vlan;               assign if_o.vlan_in = vlan;
    assign if_p.vlan_valid_in = vlan_valid;   assign if_o.vlan_valid_in = vlan_valid;
    assign if_p.ready_in = ready_in;          assign if_o.ready_in = ready_in;

    stage_action_merge #(.NUM_SUB_UNIT(NSU), .ACT_LEN(8), .NUM_PHV_CONT(2),
        .PHV_LEN(PW), .C_VLANID_WIDTH(VW), .MERGE_MODE(MERGE_PRIO),
        .CNT_WIDTH(CW)) dut_p (
        .axis_clk (clk), .aresetn (rstn), .bus (if_p.slave), .clr_cnt (clr_cnt),
        .hit_cnt (hit_p), .miss_cnt (miss_p), .multi_hit_cnt (multi_p));

    stage_action_merge #(.NUM_SUB_UNIT(NSU), .ACT_LEN(8), .NUM_PHV_CONT(2),
        .PHV_LEN(PW), .C_VLANID_WIDTH(VW), .MERGE_MODE(MERGE_OR),
        .CNT_WIDTH(CW)) dut_o (
        .axis_clk (clk), .aresetn (rstn), .bus (if_o.slave), .clr_cnt (clr_cnt),
        .hit_cnt (hit_o), .miss_cnt (miss_o), .multi_hit_cnt (multi_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference merges, written as a downward scan (last write = lowest
    // valid index) and a masked OR fold.
    function automatic logic [AW-1:0] model_prio(input logic [NSU*AW-1:0] l,
                                                 input logic [NSU-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = NSU - 1; i >= 0; i--) if (v[i]) r = l[i*AW +: AW];
        return r;
    endfunction

    function automatic logic [AW-1:0] model_or(input logic [NSU*AW-1:0] l,
                                               input logic [NSU-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < NSU; i++) r = r | (l[i*AW +: AW] & {AW{v[i]}});
        return r;
    endfunction

    function automatic logic [CW-1:0] stat(input int v);
        return STATS ? CW'(v) : '0;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one transaction and holds it until the accepting edge.
    task automatic apply_stimulus(input logic [NSU*AW-1:0] l, input logic [NSU-1:0] v,
                                  input logic [PW-1:0] p, input logic [VW-1:0] vl,
                                  input logic vv);
        int guard;
        sub_action = l; sub_valid = v; phv = p; vlan = vl; vlan_valid = vv;
        phv_valid  = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!if_p.ready_out && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_output("accept_timeout", (guard < 50), 1);
        @(posedge clk); #1;
        phv_valid = 1'b0;
        sub_valid = '1;
    endtask

    task automatic check_counters(input string tag, input int h, input int m, input int mh);
        check_output({tag, "_hit"},   hit_p,   stat(h));
        check_output({tag, "_miss"},  miss_p,  stat(m));
        check_output({tag, "_multi"}, multi_p, stat(mh));
    endtask

    // Scoreboard: compare the head beat every cycle, pop on transfer, then
    // push the transaction accepted at the coming edge.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
        end else begin
            if (if_p.valid_out) begin
                check_output("beat_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    check_output("prio_action", if_p.action_out, sb[0].act_p);
                    check_output("or_valid",    if_o.valid_out,  1);
                    check_output("or_action",   if_o.action_out, sb[0].act_o);
                    check_output("phv",         if_p.phv_out,    sb[0].phv);
                    check_output("hit_vec",     if_p.hit_vec_out, sb[0].hit);
                    check_output("vlan",        if_p.vlan_out,   sb[0].vlan);
                    check_output("vlan_valid",  if_p.vlan_valid_out, sb[0].vv);
                    if (ready_in) void'(sb.pop_front());
                end
            end else begin
                check_output("idle_vlan_valid", if_p.vlan_valid_out, 0);
            end
            if (phv_valid && if_p.ready_out) begin
                sb.push_back('{act_p: model_prio(sub_action, sub_valid),
                               act_o: model_or(sub_action, sub_valid),
                               phv: phv, hit: sub_valid, vlan: vlan,
                               vv: vlan_valid});
            end
        end
    end

    initial begin
        int guard;
        n_compared = 0; n_mismatched = 0;
        rstn = 1'b0; clr_cnt = 1'b0; ready_in = 1'b1;
        sub_action = '0; sub_valid = '0; phv = '0; phv_valid = 1'b0;
        vlan = '0; vlan_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", if_p.valid_out, 0);
        check_output("rst_ready", if_p.ready_out, 1);
        check_output("rst_action", if_p.action_out, 0);
        check_counters("rst", 0, 0, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] priority merge, lanes 2 and 5 valid");
        lanes = {NSU{16'h5A5A}};
        lanes[2*AW +: AW] = 16'hA123;
        lanes[5*AW +: AW] = 16'hB456;
        apply_stimulus(lanes, 8'h24, 16'h1001, 12'h0AB, 1'b1);
        check_output("t1_action", if_p.action_out, 16'hA123);
        check_output("t1_hitvec", if_p.hit_vec_out, 8'h24);
        check_counters("t1", 1, 0, 1);

        $display("[TB] OR merge, lanes 0 and 3 valid, lane 1 masked");
        lanes = {NSU{16'h7700}};
        lanes[0*AW +: AW] = 16'h000F;
        lanes[1*AW +: AW] = 16'hFFFF;
        lanes[3*AW +: AW] = 16'h00F0;
        apply_stimulus(lanes, 8'h09, 16'h1002, 12'h0CD, 1'b0);
        check_output("t2_or_lowbyte", if_o.action_out[7:0], 8'hFF);
        check_output("t2_or_action", if_o.action_out, 16'h00FF);
        check_output("t2_hitvec", if_o.hit_vec_out, 8'h09);
        check_counters("t2", 2, 0, 2);

        $display("[TB] no valid lanes");
        apply_stimulus({NSU{16'hFFFF}}, 8'h00, 16'h1003, 12'h001, 1'b1);
        check_output("t3_valid", if_p.valid_out, 1);
        check_output("t3_prio_nop", if_p.action_out, 0);
        check_output("t3_or_nop", if_o.action_out, 0);
        check_counters("t3", 2, 1, 2);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] backpressure with four back-to-back transactions");
        ready_in = 1'b0;
        lanes = {16'h8888, 16'h7777, 16'h6666, 16'h5555,
                 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        apply_stimulus(lanes, 8'h80, 16'h2001, 12'h101, 1'b1);
        apply_stimulus(lanes, 8'h01, 16'h2002, 12'h102, 1'b0);
        check_output("t4_ready_low", if_p.ready_out, 0);
        check_output("t4_head_is_first", if_p.phv_out, 16'h2001);
        sub_action = lanes; sub_valid = 8'h10; phv = 16'h2003;
        vlan = 12'h103; vlan_valid = 1'b1; phv_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_output("t4_stall_ready", if_p.ready_out, 0);
            check_output("t4_stall_head", if_p.phv_out, 16'h2001);
        end
        ready_in = 1'b1;
        apply_stimulus(lanes, 8'h10, 16'h2003, 12'h103, 1'b1);
        apply_stimulus(lanes, 8'h06, 16'h2004, 12'h104, 1'b1);
        check_counters("t4", 6, 1, 3);

        $display("[TB] hit counter saturation and clear");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(lanes, 8'h02, PW'(16'h3000 + i), 12'h200, 1'b0);
        end
        check_counters("sat", 15, 1, 3);
        clr_cnt = 1'b1;
        apply_stimulus(lanes, 8'h03, 16'h3100, 12'h201, 1'b1);
        clr_cnt = 1'b0;
        check_counters("clr", 0, 0, 0);

        $display("[TB] reset with both entries full");
        repeat (2) @(posedge clk);
        #1;
        ready_in = 1'b0;
        apply_stimulus(lanes, 8'h40, 16'h4001, 12'h301, 1'b1);
        apply_stimulus(lanes, 8'h40, 16'h4002, 12'h302, 1'b1);
        check_output("t6_full", if_p.ready_out, 0);
        rstn = 1'b0;
        @(posedge clk); #1;
        check_output("t6_rst_valid", if_p.valid_out, 0);
        check_output("t6_rst_ready", if_p.ready_out, 1);
        check_counters("t6_rst", 0, 0, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_output("t6_post_valid", if_p.valid_out, 0);
        check_output("t6_post_ready", if_p.ready_out, 1);
        check_output("t6_post_vlan_valid", if_p.vlan_valid_out, 0);
        ready_in = 1'b1;
        apply_stimulus(lanes, 8'h20, 16'h5001, 12'h401, 1'b1);
        check_output("t6_resume", if_p.action_out, 16'h6666);
        check_counters("t6_resume", 1, 0, 0);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output("drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
